// File: rtl/sdr_pkg.sv
// Shared types for the SDRAM toggle responder.
// Round-robin arbitration is enabled by defining SDR_ROUND_ROBIN_EN.
package sdr_pkg;

    localparam int unsigned SDR_DW  = 16;
    localparam int unsigned SDR_BEW = 2;

    localparam logic [SDR_BEW-1:0] SDR_BE_READ = 2'b11;

    typedef enum logic [1:0] {
        SDR_IDLE    = 2'd0,
        SDR_ISSUE   = 2'd1,
        SDR_WAIT_RD = 2'd2
    } sdr_state_t;

    typedef enum logic {
        SDR_PORT1 = 1'b0,
        SDR_PORT2 = 1'b1
    } sdr_port_t;

    // Write payload taken from the winning client port
    typedef struct packed {
        logic [SDR_BEW-1:0] wr_sel;
        logic [SDR_DW-1:0]  din;
    } sdr_wr_t;

    function automatic sdr_port_t sdr_other(input sdr_port_t p);
        return (p == SDR_PORT1) ? SDR_PORT2 : SDR_PORT1;
    endfunction

endpackage

// File: rtl/sdr_port_arb.sv
// Pending detection and grant between the two toggle client ports.
// SDR_ROUND_ROBIN_EN adds a preference pointer; otherwise port 1 has fixed priority.
module sdr_port_arb
    import sdr_pkg::*;
(
`ifdef SDR_ROUND_ROBIN_EN
    input  logic CLK_32M,
    input  logic reset_n,
    input  logic grant_take,
`endif
    input  logic sdr_req1,
    input  logic sdr_ack1,
    input  logic sdr_req2,
    input  logic sdr_ack2,
    output logic pend_any_c,
    output logic grant_c
);

    logic      pend1_c;
    logic      pend2_c;
    sdr_port_t win_c;

    assign pend1_c    = sdr_req1 ^ sdr_ack1;
    assign pend2_c    = sdr_req2 ^ sdr_ack2;
    assign pend_any_c = pend1_c | pend2_c;
    assign grant_c    = win_c;

`ifdef SDR_ROUND_ROBIN_EN
    sdr_port_t rr_ptr;

    always_comb begin
        win_c = SDR_PORT1;
        if (pend1_c && pend2_c) begin
            win_c = rr_ptr;
        end else if (pend2_c) begin
            win_c = SDR_PORT2;
        end
    end

    // Pointer prefers the port that did not win the last grant
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= SDR_PORT1;
        end else if (grant_take) begin
            rr_ptr <= sdr_other(win_c);
        end
    end
`else
    always_comb begin
        win_c = SDR_PORT1;
        if (!pend1_c && pend2_c) begin
            win_c = SDR_PORT2;
        end
    end
`endif

endmodule

// File: rtl/sdr_toggle_responder.sv
// SDRAM-side responder for the two-port toggle req/ack handshake; one memory-core
// command per request. Arbitration mode selected by SDR_ROUND_ROBIN_EN.
module sdr_toggle_responder
    import sdr_pkg::*;
#(
    parameter int unsigned AW = 24
) (
    input  logic          CLK_32M,
    input  logic          reset_n,

    input  logic          sdr_req1,
    output logic          sdr_ack1,
    input  logic [AW:1]   sdr_addr1,
    input  logic [1:0]    sdr_wr_sel1,
    input  logic [15:0]   sdr_din1,
    output logic [15:0]   sdr_dout1,

    input  logic          sdr_req2,
    output logic          sdr_ack2,
    input  logic [AW:1]   sdr_addr2,
    input  logic [1:0]    sdr_wr_sel2,
    input  logic [15:0]   sdr_din2,
    output logic [15:0]   sdr_dout2,

    output logic          mem_req,
    input  logic          mem_ready,
    output logic [AW:1]   mem_addr,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rvalid
);

    sdr_state_t state;
    sdr_port_t  lat_id;
    logic       lat_req;

    logic       pend_any_c;
    logic       grant_c;
    sdr_port_t  win_c;
    logic       grant_take_c;
    logic       sel_req_c;
    logic [AW:1] sel_addr_c;
    sdr_wr_t    sel_wr_c;
    logic       sel_is_wr_c;

    assign win_c        = sdr_port_t'(grant_c);
    assign grant_take_c = (state == SDR_IDLE) && pend_any_c;
    assign sel_is_wr_c  = |sel_wr_c.wr_sel;

    sdr_port_arb u_arb (
`ifdef SDR_ROUND_ROBIN_EN
        .CLK_32M    (CLK_32M),
        .reset_n    (reset_n),
        .grant_take (grant_take_c),
`endif
        .sdr_req1   (sdr_req1),
        .sdr_ack1   (sdr_ack1),
        .sdr_req2   (sdr_req2),
        .sdr_ack2   (sdr_ack2),
        .pend_any_c (pend_any_c),
        .grant_c    (grant_c)
    );

    // Request fields of the arbitration winner
    always_comb begin
        sel_req_c  = sdr_req1;
        sel_addr_c = sdr_addr1;
        sel_wr_c   = '{wr_sel: sdr_wr_sel1, din: sdr_din1};
        if (win_c == SDR_PORT2) begin
            sel_req_c  = sdr_req2;
            sel_addr_c = sdr_addr2;
            sel_wr_c   = '{wr_sel: sdr_wr_sel2, din: sdr_din2};
        end
    end

    // mem_* registers double as the latched request; lat_req is returned as ack
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SDR_IDLE;
            lat_id    <= SDR_PORT1;
            lat_req   <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            sdr_ack1  <= 1'b0;
            sdr_ack2  <= 1'b0;
            sdr_dout1 <= '0;
            sdr_dout2 <= '0;
        end else begin
            case (state)
                SDR_IDLE: begin
                    if (pend_any_c) begin
                        lat_id    <= win_c;
                        lat_req   <= sel_req_c;
                        mem_addr  <= sel_addr_c;
                        mem_we    <= sel_is_wr_c;
                        mem_be    <= sel_is_wr_c ? sel_wr_c.wr_sel : SDR_BE_READ;
                        mem_wdata <= sel_wr_c.din;
                        mem_req   <= 1'b1;
                        state     <= SDR_ISSUE;
                    end
                end
                SDR_ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            if (lat_id == SDR_PORT1) sdr_ack1 <= lat_req;
                            else                     sdr_ack2 <= lat_req;
                            state <= SDR_IDLE;
                        end else begin
                            state <= SDR_WAIT_RD;
                        end
                    end
                end
                SDR_WAIT_RD: begin
                    if (mem_rvalid) begin
                        if (lat_id == SDR_PORT1) begin
                            sdr_dout1 <= mem_rdata;
                            sdr_ack1  <= lat_req;
                        end else begin
                            sdr_dout2 <= mem_rdata;
                            sdr_ack2  <= lat_req;
                        end
                        state <= SDR_IDLE;
                    end
                end
                default: state <= SDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_toggle_responder.sv
// Scoreboard bench for sdr_toggle_responder: random client traffic against a
// reference memory, plus directed read/write, stall, spurious-strobe, arbitration and reset cases.
`timescale 1ns/1ps
module tb_sdr_toggle_responder;

    localparam int unsigned AW  = 24;
    localparam int          TMO = 300;

    typedef struct {
        logic [AW:1] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        logic        ack;
    } rsp_t;

    logic        CLK_32M = 1'b0;
    logic        reset_n = 1'b0;
    logic        sdr_req1 = 1'b0, sdr_req2 = 1'b0;
    logic        sdr_ack1, sdr_ack2;
    logic [AW:1] sdr_addr1 = '0, sdr_addr2 = '0;
    logic [1:0]  sdr_wr_sel1 = '0, sdr_wr_sel2 = '0;
    logic [15:0] sdr_din1 = '0, sdr_din2 = '0;
    logic [15:0] sdr_dout1, sdr_dout2;
    logic        mem_req;
    logic        mem_ready = 1'b0;
    logic [AW:1] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    int total = 0;
    int bad   = 0;

    bit          auto_mem = 1'b0;
    bit          rd_outstanding = 1'b0;
    int          rd_wait = 0;
    logic [AW:1] rd_addr = '0;

    cmd_t cq1[$], cq2[$];
    rsp_t rq1[$], rq2[$];
    int   grant_log[$];
    logic [15:0] ref_mem [int];
    logic [15:0] env_mem [int];

    logic        p_ack1 = 1'b0, p_ack2 = 1'b0;
    logic [15:0] p_dout1 = '0, p_dout2 = '0;

    sdr_toggle_responder #(.AW(AW)) dut (
        .CLK_32M     (CLK_32M),
        .reset_n     (reset_n),
        .sdr_req1    (sdr_req1),
        .sdr_ack1    (sdr_ack1),
        .sdr_addr1   (sdr_addr1),
        .sdr_wr_sel1 (sdr_wr_sel1),
        .sdr_din1    (sdr_din1),
        .sdr_dout1   (sdr_dout1),
        .sdr_req2    (sdr_req2),
        .sdr_ack2    (sdr_ack2),
        .sdr_addr2   (sdr_addr2),
        .sdr_wr_sel2 (sdr_wr_sel2),
        .sdr_din2    (sdr_din2),
        .sdr_dout2   (sdr_dout2),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid)
    );

    always #5 CLK_32M = ~CLK_32M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [AW:1] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    function automatic logic [15:0] env_rd(input logic [AW:1] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : 16'h0000;
    endfunction

    // Client side: drive a request and record what the memory and client should see
    task automatic issue(input int p, input bit rd, input logic [AW:1] a,
                         input logic [1:0] sel, input logic [15:0] d);
        cmd_t c;
        rsp_t r;
        c.addr  = a;
        c.we    = !rd;
        c.be    = rd ? 2'b11 : sel;
        c.wdata = d;
        r.rd    = rd;
        r.data  = ref_rd(a);
        if (!rd) ref_mem[int'(a)] = merge(ref_rd(a), d, sel);
        if (p == 1) begin
            sdr_addr1 = a; sdr_wr_sel1 = rd ? 2'b00 : sel; sdr_din1 = d;
            sdr_req1 = ~sdr_req1;
            r.ack = sdr_req1;
            cq1.push_back(c); rq1.push_back(r);
        end else begin
            sdr_addr2 = a; sdr_wr_sel2 = rd ? 2'b00 : sel; sdr_din2 = d;
            sdr_req2 = ~sdr_req2;
            r.ack = sdr_req2;
            cq2.push_back(c); rq2.push_back(r);
        end
    endtask

    task automatic wait_done(input int p);
        int n;
        n = 0;
        do begin
            @(negedge CLK_32M);
            n++;
        end while (((p == 1) ? (sdr_ack1 != sdr_req1) : (sdr_ack2 != sdr_req2)) && n < TMO);
        if (p == 1) chk("p1_done", 32'(sdr_ack1), 32'(sdr_req1));
        else        chk("p2_done", 32'(sdr_ack2), 32'(sdr_req2));
    endtask

    task automatic client_op(input int p, input bit rd);
        logic [AW:1] a;
        logic [1:0]  s;
        if (p == 1) a = AW'($urandom_range(0, 7));
        else        a = AW'($urandom_range(1, 7)) | 24'h800000;
        s = rd ? 2'b00 : 2'($urandom_range(1, 3));
        issue(p, rd, a, s, 16'($urandom));
        wait_done(p);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sdr_req1 = 1'b0; sdr_req2 = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        rd_outstanding = 1'b0;
        cq1.delete(); cq2.delete(); rq1.delete(); rq2.delete();
        repeat (2) @(negedge CLK_32M);
        reset_n = 1'b1;
    endtask

    task automatic mon_port(input int p, input logic ack, input logic pack,
                            input logic [15:0] dout, input logic [15:0] pdout);
        rsp_t r;
        if (ack != pack) begin
            chk($sformatf("p%0d_rsp_expected", p), 32'((p == 1) ? rq1.size() : rq2.size()) > 0 ? 32'd1 : 32'd0, 32'd1);
            if ((p == 1 && rq1.size() > 0) || (p == 2 && rq2.size() > 0)) begin
                r = (p == 1) ? rq1.pop_front() : rq2.pop_front();
                chk($sformatf("p%0d_ack", p), 32'(ack), 32'(r.ack));
                chk($sformatf("p%0d_dout", p), 32'(dout), r.rd ? 32'(r.data) : 32'(pdout));
            end
        end else begin
            chk($sformatf("p%0d_dout_hold", p), 32'(dout), 32'(pdout));
        end
    endtask

    // Memory-core model: random ready stalls, random read latency, spurious strobes
    initial begin
        forever begin
            @(negedge CLK_32M);
            if (auto_mem) begin
                mem_rvalid = 1'b0;
                if (rd_outstanding) begin
                    if (rd_wait == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = env_rd(rd_addr);
                        rd_outstanding = 1'b0;
                    end else begin
                        rd_wait--;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 16'($urandom);
                end
                mem_ready = ($urandom_range(0, 2) != 0);
                if (mem_req && mem_ready) begin
                    if (mem_we) begin
                        env_mem[int'(mem_addr)] = merge(env_rd(mem_addr), mem_wdata, mem_be);
                    end else begin
                        rd_outstanding = 1'b1;
                        rd_wait = int'($urandom_range(0, 2));
                        rd_addr = mem_addr;
                    end
                end
            end
        end
    end

    // Monitor: commands at acceptance, responses on every ack toggle
    initial begin
        forever begin
            @(negedge CLK_32M);
            #1;
            if (reset_n) begin
                if (mem_req && mem_ready) begin
                    int   p;
                    cmd_t c;
                    p = mem_addr[AW] ? 2 : 1;
                    grant_log.push_back(p);
                    chk("cmd_expected", ((p == 1) ? cq1.size() : cq2.size()) > 0 ? 32'd1 : 32'd0, 32'd1);
                    if ((p == 1 && cq1.size() > 0) || (p == 2 && cq2.size() > 0)) begin
                        c = (p == 1) ? cq1.pop_front() : cq2.pop_front();
                        chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
                        chk("cmd_we",   32'(mem_we),   32'(c.we));
                        chk("cmd_be",   32'(mem_be),   32'(c.be));
                        if (c.we) chk("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
                    end
                end
                mon_port(1, sdr_ack1, p_ack1, sdr_dout1, p_dout1);
                mon_port(2, sdr_ack2, p_ack2, sdr_dout2, p_dout2);
            end
            p_ack1 = sdr_ack1; p_ack2 = sdr_ack2;
            p_dout1 = sdr_dout1; p_dout2 = sdr_dout2;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_ack1"},      32'(sdr_ack1),  32'd0);
        chk({tag, "_ack2"},      32'(sdr_ack2),  32'd0);
        chk({tag, "_dout1"},     32'(sdr_dout1), 32'd0);
        chk({tag, "_dout2"},     32'(sdr_dout2), 32'd0);
    endtask

    initial begin
        #2;
        chk_reset_vals("rst");
        repeat (2) @(negedge CLK_32M);
        reset_n = 1'b1;

        // Port 1 read, ready high (also while idle), data returned two cycles later
        @(negedge CLK_32M);
        mem_ready = 1'b1;
        ref_mem[int'(24'h000100)] = 16'hBEEF;
        issue(1, 1'b1, 24'h000100, 2'b00, 16'h0000);
        @(negedge CLK_32M);
        chk("rd_mem_req",  32'(mem_req),  32'd1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h000100);
        chk("rd_mem_be",   32'(mem_be),   32'd3);
        chk("rd_mem_we",   32'(mem_we),   32'd0);
        @(negedge CLK_32M);
        mem_ready = 1'b0;
        @(negedge CLK_32M);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        wait_done(1);
        mem_rvalid = 1'b0;
        chk("rd_ack1",  32'(sdr_ack1),  32'd1);
        chk("rd_dout1", 32'(sdr_dout1), 32'hBEEF);
        chk("rd_ack2",  32'(sdr_ack2),  32'd0);
        chk("rd_dout2", 32'(sdr_dout2), 32'd0);

        // Spurious strobe while idle
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge CLK_32M);
        mem_rvalid = 1'b0;
        @(negedge CLK_32M);
        chk("idle_rv_dout1", 32'(sdr_dout1), 32'hBEEF);
        chk("idle_rv_ack1",  32'(sdr_ack1),  32'd1);

        // Port 2 write with three stall cycles and a spurious strobe in ISSUE
        issue(2, 1'b0, 24'h800000, 2'b01, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_32M);
            chk("wr_hold_req",   32'(mem_req),   32'd1);
            chk("wr_hold_addr",  32'(mem_addr),  32'h800000);
            chk("wr_hold_we",    32'(mem_we),    32'd1);
            chk("wr_hold_be",    32'(mem_be),    32'd1);
            chk("wr_hold_wdata", 32'(mem_wdata), 32'h1234);
            mem_rvalid = (i == 1);
            mem_rdata  = 16'hFFFF;
        end
        mem_ready = 1'b1;
        wait_done(2);
        mem_ready = 1'b0;
        chk("wr_ack2",  32'(sdr_ack2),  32'd1);
        chk("wr_dout2", 32'(sdr_dout2), 32'd0);
        chk("wr_dout1", 32'(sdr_dout1), 32'hBEEF);
        chk("wr_ack1",  32'(sdr_ack1),  32'd1);

        // Both ports pending together, four requests each
        do_reset();
        auto_mem = 1'b1;
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) client_op(1, 1'($urandom));
            end
            begin
                for (int k = 0; k < 4; k++) client_op(2, 1'($urandom));
            end
        join
        chk("arb_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef SDR_ROUND_ROBIN_EN
            chk($sformatf("arb_order%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
`else
            chk($sformatf("arb_order%0d", i), 32'(grant_log[i]), (i < 4) ? 32'd1 : 32'd2);
`endif
        end
        chk("arb_ack1", 32'(sdr_ack1), 32'(sdr_req1));
        chk("arb_ack2", 32'(sdr_ack2), 32'(sdr_req2));

        // Random traffic from both clients
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge CLK_32M);
                    client_op(1, 1'($urandom));
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge CLK_32M);
                    client_op(2, 1'($urandom));
                end
            end
        join

        // Reset while waiting for read data
        @(negedge CLK_32M);
        auto_mem = 1'b0;
        mem_rvalid = 1'b0;
        mem_ready = 1'b1;
        issue(1, 1'b1, 24'h000006, 2'b00, 16'h0000);
        @(negedge CLK_32M);
        @(negedge CLK_32M);
        chk("wrd_mem_req", 32'(mem_req), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        do_reset();
        mem_rvalid = 1'b1; mem_rdata = 16'hA5A5;
        @(negedge CLK_32M);
        mem_rvalid = 1'b0;
        chk("late_rv_ack1",  32'(sdr_ack1),  32'd0);
        chk("late_rv_dout1", 32'(sdr_dout1), 32'd0);
        chk("late_rv_req",   32'(mem_req),   32'd0);
        auto_mem = 1'b1;
        client_op(1, 1'b1);
        chk("post_rst_ack1",  32'(sdr_ack1),  32'd1);
        chk("post_rst_dout1", 32'(sdr_dout1), 32'(ref_rd(sdr_addr1)));

        repeat (3) @(negedge CLK_32M);
        chk("queues_empty", 32'(cq1.size() + cq2.size() + rq1.size() + rq2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
